prt_dp_lb_tmo: RTL and testbench

Local-bus read-timeout guard inserted between one downstream port of the application local-bus mux and an external register slave (DPTX, DPRX, VTB, PHY or scaler). It forwards writes and reads unchanged and registers the slave's read response. If the slave does not answer a read within a bounded number of cycles, the guard returns a fixed error word, so the RISC-V CPU can never stall on a dead or reset slave. Timeouts are reported through sticky status, a saturating counter and an interrupt pulse.

---
 rtl/prt_dp_lb_tmo_if.sv | 15 +
 rtl/prt_dp_lb_tmo.sv | 127 ++++++++++++
 tb/tb_prt_dp_lb_tmo.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/prt_dp_lb_tmo_if.sv
// Local-bus link between the application mux and one register slave.
// A read is a one-cycle rd strobe; the answer is a one-cycle vld carrying dout.
interface prt_dp_lb_if #(
  parameter int P_ADR_WIDTH = 16
);
  logic [P_ADR_WIDTH-1:0] adr;
  logic [31:0]            din;
  logic                   wr;
  logic                   rd;
  logic [31:0]            dout;
  logic                   vld;

  modport lb_in  (input adr, din, wr, rd, output dout, vld);
  modport lb_out (output adr, din, wr, rd, input dout, vld);
endinterface

// File: rtl/prt_dp_lb_tmo.sv
// Read-timeout guard for one local-bus slave: substitutes an error word when a
// read goes unanswered, so the CPU never stalls on a dead or resetting slave.
module prt_dp_lb_tmo #(
  parameter int          P_ADR_WIDTH = 16,
  parameter int          P_TMO       = 64,
  parameter logic [31:0] P_TMO_DAT   = 32'hDEAD_BEEF
) (
  input  logic        CLK_IN,
  input  logic        RST_IN,
  prt_dp_lb_if.lb_in  LB_UP_IF,
  prt_dp_lb_if.lb_out LB_DWN_IF,
  input  logic        STA_CLR_IN,
  output logic        STA_TMO_OUT,
  output logic        STA_OVR_OUT,
  output logic [7:0]  STA_CNT_OUT,
  output logic        TMO_IRQ_OUT
);

  localparam int CNT_W = $clog2(P_TMO + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [P_ADR_WIDTH-1:0] adr;
  logic                   rsp_evt;
  logic                   tmo_evt;
  logic                   ovr_evt;
  logic                   cnt_last;
  logic                   vld_p1;
  logic [31:0]            dout_p1;
  logic                   irq_p1;
  logic                   sta_tmo;
  logic                   sta_ovr;
  logic [7:0]             sta_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Writes and addressing pass straight through; only rd is gated by the FSM.
  assign adr            = LB_UP_IF.adr;
  assign LB_DWN_IF.adr  = adr;
  assign LB_DWN_IF.din  = LB_UP_IF.din;
  assign LB_DWN_IF.wr   = LB_UP_IF.wr;
  assign LB_DWN_IF.rd   = (state_q == S_IDLE) & LB_UP_IF.rd;

  assign cnt_last = (cnt_q == CNT_W'(1));

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (LB_UP_IF.rd) state_d = S_WAIT;
      S_WAIT: if (LB_DWN_IF.vld || cnt_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The slave answer is checked before the counter so a reply in the last
  // allowed cycle still wins over the timeout.
  always_comb begin
    rsp_evt = 1'b0;
    tmo_evt = 1'b0;
    ovr_evt = 1'b0;
    if (state_q == S_WAIT) begin
      rsp_evt = LB_DWN_IF.vld;
      tmo_evt = ~LB_DWN_IF.vld & cnt_last;
      ovr_evt = LB_UP_IF.rd;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= LB_UP_IF.rd ? CNT_W'(P_TMO) : '0;
    end else if (rsp_evt || tmo_evt) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Response stage p1: registered upstream answer and timeout pulse.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      vld_p1  <= 1'b0;
      irq_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      vld_p1 <= rsp_evt | tmo_evt;
      irq_p1 <= tmo_evt;
      if (rsp_evt)      dout_p1 <= LB_DWN_IF.dout;
      else if (tmo_evt) dout_p1 <= P_TMO_DAT;
    end
  end

  // Status: a coincident event takes priority over the clear pulse.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      sta_tmo <= 1'b0;
      sta_ovr <= 1'b0;
      sta_cnt <= '0;
    end else begin
      if (tmo_evt)         sta_tmo <= 1'b1;
      else if (STA_CLR_IN) sta_tmo <= 1'b0;
      if (ovr_evt)         sta_ovr <= 1'b1;
      else if (STA_CLR_IN) sta_ovr <= 1'b0;
      if (tmo_evt)         sta_cnt <= STA_CLR_IN ? 8'd1 : sat_inc(sta_cnt);
      else if (STA_CLR_IN) sta_cnt <= '0;
    end
  end

  assign LB_UP_IF.vld  = vld_p1;
  assign LB_UP_IF.dout = dout_p1;
  assign TMO_IRQ_OUT   = irq_p1;
  assign STA_TMO_OUT   = sta_tmo;
  assign STA_OVR_OUT   = sta_ovr;
  assign STA_CNT_OUT   = sta_cnt;

endmodule

// File: tb/tb_prt_dp_lb_tmo.sv
// Bench for prt_dp_lb_tmo: directed scenarios plus random traffic, checked
// every cycle against a read-age reference model.
module tb_prt_dp_lb_tmo;

  localparam int          P_TMO   = 64;
  localparam logic [31:0] TMO_DAT = 32'hDEAD_BEEF;

  logic CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  logic        b_rst   = 1'b1;
  logic        b_clr   = 1'b0;
  logic        b_rd    = 1'b0;
  logic        b_wr    = 1'b0;
  logic [15:0] b_adr   = '0;
  logic [31:0] b_din   = '0;
  logic        b_dvld  = 1'b0;
  logic [31:0] b_ddout = '0;

  logic        sta_tmo;
  logic        sta_ovr;
  logic [7:0]  sta_cnt;
  logic        tmo_irq;

  prt_dp_lb_if #(.P_ADR_WIDTH(16)) up_if ();
  prt_dp_lb_if #(.P_ADR_WIDTH(16)) dwn_if ();

  assign up_if.adr   = b_adr;
  assign up_if.din   = b_din;
  assign up_if.wr    = b_wr;
  assign up_if.rd    = b_rd;
  assign dwn_if.vld  = b_dvld;
  assign dwn_if.dout = b_ddout;

  prt_dp_lb_tmo #(
    .P_ADR_WIDTH(16),
    .P_TMO      (P_TMO),
    .P_TMO_DAT  (TMO_DAT)
  ) dut (
    .CLK_IN     (CLK_IN),
    .RST_IN     (b_rst),
    .LB_UP_IF   (up_if),
    .LB_DWN_IF  (dwn_if),
    .STA_CLR_IN (b_clr),
    .STA_TMO_OUT(sta_tmo),
    .STA_OVR_OUT(sta_ovr),
    .STA_CNT_OUT(sta_cnt),
    .TMO_IRQ_OUT(tmo_irq)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: a pending read is remembered by the cycle it was issued.
  bit          m_pend   = 1'b0;
  int          m_rd_cyc = 0;
  logic        m_vld    = 1'b0;
  logic        m_irq    = 1'b0;
  logic [31:0] m_dout   = '0;
  logic        m_tmo    = 1'b0;
  logic        m_ovr    = 1'b0;
  int          m_cnt    = 0;

  int          t_vld_n;
  int          t_vld_at;
  int          t_irq_n;
  logic [31:0] t_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic cycle();
    logic        n_vld, n_irq, n_tmo, n_ovr, n_pend;
    logic [31:0] n_dout;
    int          n_cnt, n_rc;
    #1;
    chk("dwn_rd", dwn_if.rd, (!m_pend && b_rd));
    chk("dwn_pass", {dwn_if.adr, dwn_if.din, dwn_if.wr}, {b_adr, b_din, b_wr});
    n_vld = 1'b0; n_irq = 1'b0; n_dout = m_dout;
    n_tmo = m_tmo; n_ovr = m_ovr; n_cnt = m_cnt;
    n_pend = m_pend; n_rc = m_rd_cyc;
    if (b_clr) begin
      n_tmo = 1'b0; n_ovr = 1'b0; n_cnt = 0;
    end
    if (m_pend) begin
      if (b_rd) n_ovr = 1'b1;
      if (b_dvld) begin
        n_vld = 1'b1; n_dout = b_ddout; n_pend = 1'b0;
      end else if (cyc - m_rd_cyc == P_TMO) begin
        n_vld = 1'b1; n_dout = TMO_DAT; n_irq = 1'b1; n_tmo = 1'b1; n_pend = 1'b0;
        n_cnt = b_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end
    end else if (b_rd) begin
      n_pend = 1'b1; n_rc = cyc;
    end
    if (b_rst) begin
      n_vld = 1'b0; n_irq = 1'b0; n_dout = '0; n_tmo = 1'b0; n_ovr = 1'b0;
      n_cnt = 0; n_pend = 1'b0;
    end
    @(posedge CLK_IN);
    #1;
    m_vld = n_vld; m_irq = n_irq; m_dout = n_dout; m_tmo = n_tmo; m_ovr = n_ovr;
    m_cnt = n_cnt; m_pend = n_pend; m_rd_cyc = n_rc;
    chk("up_vld", up_if.vld, m_vld);
    chk("up_dout", up_if.dout, m_dout);
    chk("irq", tmo_irq, m_irq);
    chk("sta_tmo", sta_tmo, m_tmo);
    chk("sta_ovr", sta_ovr, m_ovr);
    chk("sta_cnt", sta_cnt, m_cnt[7:0]);
    cyc++;
  endtask

  // One read issued at k=0; other events placed at the given relative cycles (-1 = none).
  task automatic txn(input int lat, input logic [31:0] d, input int len, input int ovr_at,
                     input int wr_at, input int clr_at, input int rst_at, input int late_at);
    t_vld_n = 0; t_vld_at = -1; t_irq_n = 0; t_dout = '0;
    for (int k = 0; k < len; k++) begin
      b_rd    = (k == 0) || (k == ovr_at);
      b_wr    = (k == wr_at);
      b_clr   = (k == clr_at);
      b_rst   = (k == rst_at);
      b_dvld  = (k == lat) || (k == late_at);
      b_ddout = b_dvld ? d : $urandom;
      b_adr   = 16'($urandom);
      b_din   = $urandom;
      cycle();
      if (up_if.vld === 1'b1) begin
        t_vld_n++;
        if (t_vld_at < 0) begin
          t_vld_at = k + 1;
          t_dout   = up_if.dout;
        end
      end
      if (tmo_irq === 1'b1) t_irq_n++;
    end
    b_rd = 1'b0; b_wr = 1'b0; b_clr = 1'b0; b_rst = 1'b0; b_dvld = 1'b0;
  endtask

  initial begin
    b_rst = 1'b1;
    cycle();
    cycle();
    b_rst = 1'b0;
    chk("rst_vld", up_if.vld, 1'b0);
    chk("rst_dout", up_if.dout, 32'h0);
    chk("rst_sta", {sta_tmo, sta_ovr, sta_cnt, tmo_irq}, 11'h0);

    txn(5, 32'h1234_5678, 8, -1, -1, -1, -1, -1);
    chk("norm_at", t_vld_at, 6);
    chk("norm_dout", t_dout, 32'h1234_5678);
    chk("norm_sta", {sta_tmo, sta_cnt}, 9'h0);

    txn(-1, 32'h5555_AAAA, 75, -1, -1, -1, -1, 70);
    chk("dead_at", t_vld_at, 65);
    chk("dead_dout", t_dout, TMO_DAT);
    chk("dead_nvld", t_vld_n, 1);
    chk("dead_irq", t_irq_n, 1);
    chk("dead_sta", {sta_tmo, sta_cnt}, {1'b1, 8'd1});

    txn(64, 32'hCAFE_0064, 67, -1, -1, -1, -1, -1);
    chk("b64_at", t_vld_at, 65);
    chk("b64_dout", t_dout, 32'hCAFE_0064);
    chk("b64_irq", t_irq_n, 0);

    txn(65, 32'hCAFE_0065, 68, -1, -1, -1, -1, -1);
    chk("b65_at", t_vld_at, 65);
    chk("b65_dout", t_dout, TMO_DAT);
    chk("b65_nvld", t_vld_n, 1);

    txn(8, 32'h0BAD_F00D, 11, 3, 4, -1, -1, -1);
    chk("ovr_nvld", t_vld_n, 1);
    chk("ovr_at", t_vld_at, 9);
    chk("ovr_dout", t_dout, 32'h0BAD_F00D);
    chk("ovr_sta", sta_ovr, 1'b1);

    // Each read starts on the cycle the previous timeout answer is driven.
    for (int i = 0; i < 300; i++) txn(-1, 32'h0, 65, -1, -1, -1, -1, -1);
    chk("sat_cnt", sta_cnt, 8'd255);
    b_clr = 1'b1;
    cycle();
    b_clr = 1'b0;
    chk("clr_sta", {sta_tmo, sta_ovr, sta_cnt}, 10'h0);

    txn(-1, 32'h0, 66, -1, -1, 64, -1, -1);
    chk("clrtmo_cnt", sta_cnt, 8'd1);
    chk("clrtmo_tmo", sta_tmo, 1'b1);

    txn(10, 32'h7777_0001, 12, 2, -1, 2, -1, -1);
    chk("clrovr_ovr", sta_ovr, 1'b1);
    chk("clrovr_cnt", sta_cnt, 8'd0);

    txn(15, 32'h9999_0015, 20, -1, -1, -1, 10, -1);
    chk("rstrd_nvld", t_vld_n, 0);
    chk("rstrd_sta", {sta_tmo, sta_ovr, sta_cnt, tmo_irq}, 11'h0);
    txn(5, 32'h4242_4242, 8, -1, -1, -1, -1, -1);
    chk("postrst_at", t_vld_at, 6);
    chk("postrst_dout", t_dout, 32'h4242_4242);

    for (int i = 0; i < 4000; i++) begin
      b_rd    = ($urandom_range(0, 15) == 0);
      b_wr    = ($urandom_range(0, 3) == 0);
      b_dvld  = ($urandom_range(0, 39) == 0);
      b_clr   = ($urandom_range(0, 99) == 0);
      b_rst   = ($urandom_range(0, 999) == 0);
      b_ddout = $urandom;
      b_adr   = 16'($urandom);
      b_din   = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
